// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Result vectors are one-hot {eq, gr, le}; RES_NONE is the cleared state.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_EQ   = 3'b100;
  localparam res_t RES_GR   = 3'b010;
  localparam res_t RES_LE   = 3'b001;

  function automatic int idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cmp_seq_if.sv
// Start/busy/done handshake and operand/result bundle for cmp_seq.
interface cmp_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gr;
  logic             le;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, gr, le
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, gr, le
  );
endinterface

// File: rtl/cmp_chunk.sv
// Combinational unsigned magnitude comparator for one CHUNK-bit slice.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gr,
  output logic             le
);

  assign eq = (a == b);
  assign gr = (a > b);
  assign le = (a < b);

endmodule

// File: rtl/cmp_seq.sv
// Sequential MSB-first magnitude comparator: one CHUNK-bit slice per clock,
// unsigned or two's-complement, terminating on the first differing slice.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic       clk,
  input logic       rst_n,
  cmp_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("cmp_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  res_t             res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] sl_a, sl_b;
  logic             c_eq, c_gr, c_le;

  // Flipping both sign bits on the top slice maps two's-complement order
  // onto unsigned order, so one unsigned slice comparator serves both modes.
  always_comb begin
    sl_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    sl_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
    if (sm_q && idx_q == IDX_TOP) begin
      sl_a[CHUNK-1] = ~sl_a[CHUNK-1];
      sl_b[CHUNK-1] = ~sl_b[CHUNK-1];
    end
  end

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (sl_a),
    .b  (sl_b),
    .eq (c_eq),
    .gr (c_gr),
    .le (c_le)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sm_d    = bus.signed_mode;
          idx_d   = IDX_TOP;
          res_d   = RES_NONE;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (c_gr || c_le || (c_eq && idx_q == '0)) begin
          res_d   = c_gr ? RES_GR : (c_le ? RES_LE : RES_EQ);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      res_q   <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = res_q[2];
  assign bus.gr   = res_q[1];
  assign bus.le   = res_q[0];

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
Parametrised sequential magnitude comparator. It is the multi-cycle successor of the team's 4-bit combinational comparator. Compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per clock, in unsigned or two's-complement mode, and terminates early on the first differing slice. A start/busy/done handshake lets wide compares share one narrow compare slice in datapaths where area matters more than latency.

Parameters:
WIDTH, 16, operand width in bits; must be at least 1
CHUNK, 4, bits compared per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails
NCHUNK, WIDTH/CHUNK, derived local constant for the slice count; not overridable

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a compare; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  compare in progress
done  output  1  one-cycle pulse; eq/gr/le are valid from this cycle
eq  output  1  a == b
gr  output  1  a > b
le  output  1  a < b (strictly less, matching the existing comparator's meaning)

Behaviour:
- Reset (async assert, rst_n low): state=IDLE; busy, done, eq, gr and le all 0; slice index = NCHUNK-1. Reset during RUN aborts the compare with no done pulse. Deassertion is synchronous to clk at the integration level.
- FSM states: IDLE and RUN.
- IDLE, start=1 at a rising edge:
  - latch a, b and signed_mode;
  - index = NCHUNK-1;
  - clear eq/gr/le to 0;
  - busy=1; go to RUN.
- Start while busy=1 is ignored. It is not queued.
- RUN, each cycle: compare slice [index*CHUNK +: CHUNK] of the latched operands as unsigned values.
  - In signed mode, on the top slice (index = NCHUNK-1), invert the MSB of both operands before comparing (offset-binary trick). All lower slices always compare unsigned.
  - Slices differ: at the edge, register gr or le accordingly, pulse done=1, set busy=0, go to IDLE.
  - Slices equal and index=0: register eq=1, pulse done, set busy=0, go to IDLE.
  - Slices equal and index>0: decrement index, stay in RUN.
- Latency: start accepted at edge T, so the deciding slice is registered at edge T+k, with k = 1..NCHUNK.
  - k is the position of the first differing slice counted from the MSB, or NCHUNK when the operands are equal.
  - With CHUNK=WIDTH the latency is always 1.
- done is high for exactly one cycle. Because busy=0 in that same cycle, a start asserted during the done cycle is accepted at the next edge (back-to-back operation with no gap cycle).
- eq/gr/le hold their values until the next start is accepted, then clear.
- Invariants:
  - exactly one of eq/gr/le is 1 whenever done=1;
  - all three are 0 while busy=1;
  - done and busy are never both 1.
- Live a/b/signed_mode changes while busy have no effect.

Decomposition:
- Package cmp_pkg:
  - state typedef (IDLE, RUN);
  - result-encoding constants (RES_EQ, RES_GR, RES_LE) used by both RTL and bench;
  - index-width helper function ($clog2(NCHUNK), minimum 1).
- Sub-module cmp_chunk: parametrised combinational CHUNK-bit unsigned comparator with outputs eq/gr/le. It is instantiated once in cmp_seq and fed by a slice mux. The FSM, index counter and result registers stay in cmp_seq.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
1. Reset: start with a=16'h1234, b=16'h1234; drop rst_n at the 2nd RUN cycle -> busy/done/eq/gr/le=0 immediately, and no done pulse after release.
2. Unsigned MSB decision: a=16'h8000, b=16'h7FFF, signed_mode=0 -> done at T+1, gr=1, eq=le=0. Same operands with signed_mode=1 -> done at T+1, le=1.
3. Full-length compares:
   - a=b=16'h1234 -> done at T+4, eq=1.
   - a=16'h12A4, b=16'h12A5 -> done at T+4, le=1.
   - a=16'h1300, b=16'h12FF -> done at T+2, gr=1.
4. Signed edge values:
   - a=16'hFFFF (-1), b=16'h0000, signed -> T+1, le=1.
   - a=16'h8000, b=16'h8001, signed -> T+4, le=1.
   - a=16'h7FFF, b=16'h8000, unsigned -> T+1, le=1.
5. Handshake:
   - hold start high through a 4-cycle compare -> only one compare, and busy drops with done;
   - start during the done cycle with a=16'h0001, b=16'h0000 -> accepted at the next edge, gr=1 four cycles later;
   - change a/b mid-run -> result unaffected.
6. Parameter corners:
   - CHUNK=WIDTH=8: every compare is done at T+1;
   - WIDTH=8, CHUNK=1: a=8'h01, b=8'h00 -> done at T+8, gr=1;
   - 1000 random operand pairs in both modes checked against the reference operators a==b, a>b, a<b (cast to signed when signed_mode=1), with k checked against the first differing slice.
